sevenseg_scan_driver: RTL and testbench
=======================================

# sevenseg_scan_driver

Parametrised, time-multiplexed seven-segment display driver for a common-anode bank of DIGITS digits. It replaces the single-digit combinational decoder with these additions: full hex decode, a per-digit decimal point, blank and blink controls, tear-free double-buffered loading, and a prescaled anode scan. It sits between the datapath, which loads nibbles, and the board display pins.

## Interface
- DIGITS, 4: number of multiplexed digits (≥2).
- DIV, 50000: clock cycles each digit is driven (≥2).
- BLINK_FRAMES, 64: full scan frames per blink half-period (≥1).
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  scan enable; low freezes counters and turns all anodes off.
- load  in  1  one-cycle strobe; captures data_in, dp_in, blank_in, blink_in.
- data_in  in  4*DIGITS  hex nibbles; digit i = data_in[4i+3:4i].
- dp_in  in  DIGITS  decimal point request per digit.
- blank_in  in  DIGITS  digit forced dark.
- blink_in  in  DIGITS  digit dark during blink-off phase.
- seg  out  7  active-low segments, seg[0]=a … seg[6]=g.
- dp  out  1  active-low decimal point.
- an  out  DIGITS  active-low anode select, one-hot-low when scanning.
- frame_tick  out  1  one-cycle pulse per completed scan frame.

## Operation
- Prescaler pcnt counts 0..DIV-1 while enable=1. At pcnt=DIV-1, pcnt wraps to 0 and digit index idx advances. idx wraps from DIGITS-1 to 0.
- Wrap cycle: the cycle where pcnt=DIV-1 and idx=DIGITS-1. frame_tick is registered high for exactly the one cycle after the wrap edge.
- Blink counter counts frame wraps 0..BLINK_FRAMES-1. At terminal count it clears and toggles blink_ph. blink_ph=0 means visible.
- Double buffer:
  - load with no wrap in the same cycle: shadow regs ← inputs and pending ← 1. A later load overwrites the shadow; the last load wins.
  - Wrap cycle with load=1: active ← inputs directly and pending ← 0.
  - Wrap cycle with load=0 and pending=1: active ← shadow and pending ← 0.
  - Active regs never change outside a wrap cycle, so no partially updated frame is ever displayed.
- Decode for digit idx uses active nibble n. Active-high gfedcba values: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. seg is the bitwise inverse.
- Digit dark when blank[idx]=1, or when blink[idx]=1 and blink_ph=1. A dark digit drives seg=7F, dp=1 and an all-ones for its slot, and the scan timing is unchanged. Blank has priority over blink.
- dp = ~dp_active[idx] when the digit is not dark.
- enable=0: pcnt, idx and blink state hold, an=all ones, seg=7F, dp=1, frame_tick=0. The load/shadow path stays operational. A load with enable=0 is only ever pending, because no wrap occurs.

## Timing
- Reset values: pcnt=0, idx=0, blink_ph=0, blink count=0, pending=0, active and shadow regs=0. Outputs: seg=7F, dp=1, an=all ones, frame_tick=0.
- First scan output: the first rising edge with enable=1 and rst low registers digit 0 of the active regs. With reset data this is an=...1110 and seg=40 (digit "0").
- seg, dp and an are registered and reflect idx, active regs and blink_ph from the previous cycle, giving one cycle of latency. an changes on exactly the same edge as seg, so there is no ghosting cycle.
- Each digit is driven for exactly DIV cycles, and a frame lasts DIGITS*DIV cycles.
- Load-to-display latency: the first frame that starts after the load, at most DIGITS*DIV+1 cycles.
- rst mid-frame forces all reset values immediately and asynchronously. Any pending load is discarded.

## Test plan
- Reset, then enable=1 with DIGITS=4, DIV=4 → an walks 1110,1101,1011,0111, each for 4 cycles. frame_tick pulses every 16 cycles. seg=40 throughout.
- load with data_in=16'hA810 at idx=1 → the display is unchanged until the wrap. The next frame shows digits 0..3 as seg 40, 79, 00, 08.
- Two loads in one frame (16'h1111 then 16'hFFFF), then a load coincident with the wrap cycle (16'h0808) → the next frame shows 08 data directly and the shadowed FFFF is never displayed.
- blank_in=0010 and dp_in=0001 loaded → digit 1 slot gives an=1111, seg=7F, dp=1. Digit 0 gives dp=0.
- blink_in=1000 with BLINK_FRAMES=2 → digit 3 is visible for 2 frames, dark for 2 frames, then repeats.
- enable dropped mid-digit for 5 cycles, then rst pulsed mid-frame → outputs are dark and counters hold during disable. rst gives the immediate reset values and clears pending.

Source files
------------

// File: rtl/sevenseg_scan_driver.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_driver
//   Time-multiplexed seven-segment driver for a common-anode bank of DIGITS
//   digits. Full hex decode, per-digit decimal point, blank and blink
//   controls, and a double-buffered load path so that a new value only ever
//   replaces the displayed one at a frame boundary.
//
// Parameters
//   DIGITS       number of multiplexed digits (>= 2)
//   DIV          clock cycles each digit is driven (>= 2)
//   BLINK_FRAMES full scan frames per blink half-period (>= 1)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   enable     in   scan enable; low freezes the scan and darkens the display
//   load       in   one-cycle strobe capturing data_in/dp_in/blank_in/blink_in
//   data_in    in   hex nibbles, digit i = data_in[4i+3:4i]
//   dp_in      in   decimal point request per digit
//   blank_in   in   digit forced dark
//   blink_in   in   digit dark during the blink-off phase
//   seg        out  active-low segments, seg[0]=a .. seg[6]=g
//   dp         out  active-low decimal point
//   an         out  active-low anode select, one-hot-low while scanning
//   frame_tick out  one-cycle pulse after each completed scan frame
// ---------------------------------------------------------------------------
module sevenseg_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int DIV          = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic [DIGITS-1:0]     blink_in,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES - 1);

    localparam logic [DIGITS-1:0] AN_OFF = '1;
    localparam logic [DIGITS-1:0] AN_ONE = DIGITS'(1);

    // Active-high gfedcba pattern for one hex nibble.
    function automatic logic [6:0] f_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Scan state
    logic [PW-1:0] r_pcnt;
    logic [IW-1:0] r_idx;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_ph;

    // Displayed (active) and staged (shadow) digit state
    logic [DIGITS-1:0][3:0] r_act_data, r_sh_data;
    logic [DIGITS-1:0]      r_act_dp,   r_sh_dp;
    logic [DIGITS-1:0]      r_act_blank, r_sh_blank;
    logic [DIGITS-1:0]      r_act_blink, r_sh_blink;
    logic                   r_pending;

    // Registered outputs
    logic [6:0]        r_seg;
    logic              r_dp;
    logic [DIGITS-1:0] r_an;
    logic              r_frame_tick;

    logic              w_tick;
    logic              w_wrap;
    logic              w_dark;
    logic [6:0]        w_seg_nxt;
    logic              w_dp_nxt;
    logic [DIGITS-1:0] w_an_nxt;

    assign w_tick = enable && (r_pcnt == P_LAST);
    // Last cycle of the last digit: the only point where active regs change.
    assign w_wrap = w_tick && (r_idx == I_LAST);

    // Blank wins over blink simply by being OR-ed in unconditionally.
    assign w_dark = r_act_blank[r_idx] | (r_act_blink[r_idx] & r_blink_ph);

    always_comb begin
        w_seg_nxt = 7'h7F;
        w_dp_nxt  = 1'b1;
        w_an_nxt  = AN_OFF;
        if (enable && !w_dark) begin
            w_seg_nxt = ~f_decode(r_act_data[r_idx]);
            w_dp_nxt  = ~r_act_dp[r_idx];
            w_an_nxt  = ~(AN_ONE << r_idx);
        end
    end

    // Prescaler, digit index and blink phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt      <= '0;
            r_idx       <= '0;
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if (enable) begin
            if (w_tick) begin
                r_pcnt <= '0;
                r_idx  <= (r_idx == I_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_pcnt <= r_pcnt + 1'b1;
            end
            if (w_wrap) begin
                if (r_blink_cnt == B_LAST) begin
                    r_blink_cnt <= '0;
                    r_blink_ph  <= ~r_blink_ph;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

    // Double buffer: a load at the wrap goes straight to the active regs,
    // otherwise it is staged and promoted at the next wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act_data  <= '0;
            r_act_dp    <= '0;
            r_act_blank <= '0;
            r_act_blink <= '0;
            r_sh_data   <= '0;
            r_sh_dp     <= '0;
            r_sh_blank  <= '0;
            r_sh_blink  <= '0;
            r_pending   <= 1'b0;
        end else if (w_wrap) begin
            if (load) begin
                r_act_data  <= data_in;
                r_act_dp    <= dp_in;
                r_act_blank <= blank_in;
                r_act_blink <= blink_in;
            end else if (r_pending) begin
                r_act_data  <= r_sh_data;
                r_act_dp    <= r_sh_dp;
                r_act_blank <= r_sh_blank;
                r_act_blink <= r_sh_blink;
            end
            r_pending <= 1'b0;
        end else if (load) begin
            r_sh_data  <= data_in;
            r_sh_dp    <= dp_in;
            r_sh_blank <= blank_in;
            r_sh_blink <= blink_in;
            r_pending  <= 1'b1;
        end
    end

    // Output register: seg and an share one edge so there is no ghost cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_an         <= AN_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_seg        <= w_seg_nxt;
            r_dp         <= w_dp_nxt;
            r_an         <= w_an_nxt;
            r_frame_tick <= w_wrap;
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_sevenseg_scan_driver
//   Directed plus randomized bench for sevenseg_scan_driver with DIGITS=4,
//   DIV=4, BLINK_FRAMES=2. A reference model tracks the scan as a plain count
//   of enabled cycles within a frame and a count of completed frames.
// ---------------------------------------------------------------------------
module tb_sevenseg_scan_driver;

    localparam int D  = 4;
    localparam int V  = 4;
    localparam int BF = 2;
    localparam int FL = D * V;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          load;
    logic [15:0]   data_in;
    logic [3:0]    dp_in, blank_in, blink_in;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          frame_tick;

    sevenseg_scan_driver #(.DIGITS(D), .DIV(V), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load),
        .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
        .blink_in(blink_in), .seg(seg), .dp(dp), .an(an),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [6:0] TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state
    int          m_cnt;      // enabled cycles into the current frame
    int          m_frames;   // completed frames since reset
    logic [15:0] m_data, s_data;
    logic [3:0]  m_dp, m_blank, m_blink, s_dp, s_blank, s_blink;
    bit          m_pend;

    task automatic model_reset();
        m_cnt = 0; m_frames = 0; m_pend = 0;
        m_data = '0; m_dp = '0; m_blank = '0; m_blink = '0;
        s_data = '0; s_dp = '0; s_blank = '0; s_blink = '0;
    endtask

    // One clock with the given inputs; model predicts, DUT is sampled 1ns later.
    task automatic step(input bit en, input bit ld, input logic [15:0] d,
                        input logic [3:0] dpi, input logic [3:0] bki,
                        input logic [3:0] bli);
        int         idx;
        bit         wrap, ph, dark;
        logic [3:0] one;
        logic [6:0] e_seg;
        logic       e_dp, e_ft;
        logic [3:0] e_an;
        enable = en; load = ld; data_in = d;
        dp_in = dpi; blank_in = bki; blink_in = bli;
        idx  = m_cnt / V;
        wrap = en && (m_cnt == FL - 1);
        ph   = ((m_frames / BF) % 2) == 1;
        dark = m_blank[idx] || (m_blink[idx] && ph);
        one  = 4'b0001;
        e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_ft = wrap;
        if (en && !dark) begin
            e_seg = ~TBL[m_data[idx*4 +: 4]];
            e_dp  = ~m_dp[idx];
            e_an  = ~(one << idx);
        end
        @(posedge clk);
        if (wrap) begin
            if (ld) begin
                m_data = d; m_dp = dpi; m_blank = bki; m_blink = bli;
            end else if (m_pend) begin
                m_data = s_data; m_dp = s_dp; m_blank = s_blank; m_blink = s_blink;
            end
            m_pend = 0;
            m_frames++;
        end else if (ld) begin
            s_data = d; s_dp = dpi; s_blank = bki; s_blink = bli;
            m_pend = 1;
        end
        if (en) m_cnt = (m_cnt + 1) % FL;
        #1;
        checks++;
        assert (seg === e_seg) else begin
            errors++; $error("FAIL seg: got %h want %h (t=%0t)", seg, e_seg, $time);
        end
        checks++;
        assert (dp === e_dp) else begin
            errors++; $error("FAIL dp: got %b want %b (t=%0t)", dp, e_dp, $time);
        end
        checks++;
        assert (an === e_an) else begin
            errors++; $error("FAIL an: got %b want %b (t=%0t)", an, e_an, $time);
        end
        checks++;
        assert (frame_tick === e_ft) else begin
            errors++; $error("FAIL frame_tick: got %b want %b (t=%0t)", frame_tick, e_ft, $time);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 16'h0, 4'h0, 4'h0, 4'h0);
    endtask

    // Advance with no load until the model's pre-edge frame position equals p.
    task automatic run_to(input int p);
        for (int i = 0; i < 2 * FL && m_cnt != p; i++) idle(1);
        checks++;
        assert (m_cnt == p) else begin
            errors++; $error("FAIL run_to: got %0d want %0d", m_cnt, p);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        checks++;
        assert (seg === 7'h7F && dp === 1'b1 && an === 4'hF && frame_tick === 1'b0) else begin
            errors++;
            $error("FAIL %s: got seg=%h dp=%b an=%b ft=%b want 7f/1/1111/0",
                   tag, seg, dp, an, frame_tick);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 0; load = 0; data_in = '0;
        dp_in = '0; blank_in = '0; blink_in = '0;
        model_reset();
        #12;
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Plain scan of reset data: first edge shows digit 0, seg=40.
        step(1, 0, 16'h0, 4'h0, 4'h0, 4'h0);
        checks++;
        assert (an === 4'b1110 && seg === 7'h40) else begin
            errors++; $error("FAIL first_scan: got an=%b seg=%h want 1110/40", an, seg);
        end
        idle(35);

        // Load mid-frame at digit 1; visible only from the next frame.
        run_to(V);
        step(1, 1, 16'hA810, 4'h0, 4'h0, 4'h0);
        run_to(0);
        run_to(3 * V);
        idle(1);
        checks++;
        assert (seg === 7'h08 && an === 4'b0111) else begin
            errors++; $error("FAIL digit3_A: got seg=%h an=%b want 08/0111", seg, an);
        end
        idle(FL);

        // Two staged loads then a load on the wrap cycle: FFFF never shows.
        run_to(2);
        step(1, 1, 16'h1111, 4'h0, 4'h0, 4'h0);
        step(1, 1, 16'hFFFF, 4'h0, 4'h0, 4'h0);
        run_to(FL - 1);
        step(1, 1, 16'h0808, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < FL; i++) begin
            idle(1);
            checks++;
            assert (seg !== 7'h0E) else begin
                errors++; $error("FAIL no_shadow_F: got seg=%h want not 0e", seg);
            end
        end

        // Blank digit 1, decimal point on digit 0.
        step(1, 1, 16'h0000, 4'b0001, 4'b0010, 4'b0000);
        idle(2 * FL + 4);

        // Blink digit 3; two frames visible, two dark.
        step(1, 1, 16'h4321, 4'b0000, 4'b0000, 4'b1000);
        idle(5 * FL);

        // Disable mid-digit, resume, then async reset with a load pending.
        run_to(V + 1);
        for (int i = 0; i < 5; i++) step(0, 0, 16'h0, 4'h0, 4'h0, 4'h0);
        step(0, 1, 16'h5555, 4'h0, 4'h0, 4'h0);
        idle(3);
        step(1, 1, 16'h1234, 4'hF, 4'h0, 4'h0);
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        model_reset();
        #1;
        rst = 1'b0;
        idle(2 * FL);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0,
                 16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
                 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
